// File: rtl/cpu_run_ctl_pkg.sv
// ---------------------------------------------------------------------------
// cpu_run_ctl_pkg
// Shared types and constants for the CPU run/halt/step controller.
//   run_state_t          : controller state, encoded as seen on the 'state' port
//   DRAIN_CYCLES_DEFAULT : default pipeline drain length after fetch freezes
//   DRAIN_CNT_W          : width of the drain down-counter
// ---------------------------------------------------------------------------
package cpu_run_ctl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_HALTING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_STEP    = 2'd3
    } run_state_t;

    localparam int unsigned DRAIN_CYCLES_DEFAULT = 4;
    localparam int unsigned DRAIN_CNT_W          = 3;

endpackage

// File: rtl/cpu_run_ctl_bkpt.sv
// ---------------------------------------------------------------------------
// cpu_bkpt_match
// Single-address instruction breakpoint comparator with re-arm logic.
// Only compiled when CPU_RUN_CTL_BKPT_EN is defined.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   in_run        : controller is in RUN (only state where a match may fire)
//   fetch_accept  : fetch advanced this cycle (re-arms the comparator)
//   leave_halted  : controller is leaving HALTED this cycle
//   bkpt_valid    : breakpoint enable
//   pc            : PC in the fetch stage
//   bkpt_addr     : breakpoint PC
//   match         : breakpoint fires this cycle (combinational)
//   bkpt_hit      : sticky "last halt was a breakpoint" flag
// ---------------------------------------------------------------------------
`ifdef CPU_RUN_CTL_BKPT_EN
module cpu_bkpt_match (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_run,
    input  logic        fetch_accept,
    input  logic        leave_halted,
    input  logic        bkpt_valid,
    input  logic [31:0] pc,
    input  logic [31:0] bkpt_addr,
    output logic        match,
    output logic        bkpt_hit
);

    logic arm_q;
    logic hit_q;

    assign match    = in_run && arm_q && bkpt_valid && (pc == bkpt_addr);
    assign bkpt_hit = hit_q;

    // Disarm on resume so the instruction sitting on the breakpoint PC can be
    // fetched once; re-arm as soon as fetch has actually moved past it.
    always_ff @(posedge clk) begin
        if (rst) begin
            arm_q <= 1'b1;
            hit_q <= 1'b0;
        end else if (leave_halted) begin
            arm_q <= 1'b0;
            hit_q <= 1'b0;
        end else begin
            if (fetch_accept) begin
                arm_q <= 1'b1;
            end
            if (match) begin
                hit_q <= 1'b1;
            end
        end
    end

endmodule
`endif

// File: rtl/cpu_run_ctl.sv
// ---------------------------------------------------------------------------
// cpu_run_ctl
// Debug run-control for a pipelined CPU: free-run, halt with pipeline drain,
// single-step, and (optionally) a PC breakpoint.
// Optional feature macro: CPU_RUN_CTL_BKPT_EN (instantiates cpu_bkpt_match;
// without it bkpt_hit is 0 and the breakpoint inputs are ignored).
// Parameters:
//   DRAIN_CYCLES : cycles for in-flight instructions to leave (1..7)
//   RESET_HALTED : 0 = come out of reset in RUN, 1 = in HALTED
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   halt_req     : stop issuing and drain
//   run_req      : resume free-running from HALTED
//   step_req     : issue one instruction from HALTED
//   stall_2a     : decode stall, fetch does not advance while high
//   kill_4a      : memory-stage flush of younger instructions
//   pc_1a        : fetch-stage PC
//   bkpt_valid   : breakpoint enable
//   bkpt_addr    : breakpoint PC
//   fetch_hold   : freeze fetch / insert bubbles
//   halted       : high in HALTED only
//   state        : RUN=0, HALTING=1, HALTED=2, STEP=3
//   step_done    : one-cycle pulse when a single step finishes draining
//   bkpt_hit     : last halt was caused by the breakpoint
//   run_cycles   : cycles spent in RUN, wraps at 2^32
// ---------------------------------------------------------------------------
module cpu_run_ctl
    import cpu_run_ctl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
    parameter bit          RESET_HALTED = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_req,
    input  logic        run_req,
    input  logic        step_req,
    input  logic        stall_2a,
    input  logic        kill_4a,
    input  logic [31:0] pc_1a,
    input  logic        bkpt_valid,
    input  logic [31:0] bkpt_addr,
    output logic        fetch_hold,
    output logic        halted,
    output logic [1:0]  state,
    output logic        step_done,
    output logic        bkpt_hit,
    output logic [31:0] run_cycles
);

    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);

    run_state_t             state_q;
    run_state_t             state_d;
    logic [DRAIN_CNT_W-1:0] drain_q;
    logic [DRAIN_CNT_W-1:0] drain_d;
    logic [DRAIN_CNT_W-1:0] drain_kill;
    logic [DRAIN_CNT_W-1:0] drain_next;
    logic                   step_flag_q;
    logic                   step_flag_d;
    logic                   step_done_q;
    logic                   step_done_d;
    logic [31:0]            run_cycles_q;
    logic                   bkpt_match;

    assign state      = state_q;
    assign halted     = (state_q == ST_HALTED);
    assign step_done  = step_done_q;
    assign run_cycles = run_cycles_q;

`ifdef CPU_RUN_CTL_BKPT_EN
    logic fetch_accept;
    logic leave_halted;

    assign fetch_accept = !stall_2a && ((state_q == ST_RUN) || (state_q == ST_STEP));
    assign leave_halted = (state_q == ST_HALTED) && (run_req || step_req);

    cpu_bkpt_match u_bkpt (
        .clk          (clk),
        .rst          (rst),
        .in_run       (state_q == ST_RUN),
        .fetch_accept (fetch_accept),
        .leave_halted (leave_halted),
        .bkpt_valid   (bkpt_valid),
        .pc           (pc_1a),
        .bkpt_addr    (bkpt_addr),
        .match        (bkpt_match),
        .bkpt_hit     (bkpt_hit)
    );
`else
    logic unused_bkpt_inputs;

    assign unused_bkpt_inputs = ^{bkpt_valid, bkpt_addr, pc_1a};
    assign bkpt_match         = 1'b0;
    assign bkpt_hit           = 1'b0;
`endif

    // A flush leaves at most one instruction to retire, so it clamps the
    // remaining drain to 1; a stalled cycle retires nothing.
    always_comb begin
        drain_kill = (kill_4a && (drain_q > DRAIN_ONE)) ? DRAIN_ONE : drain_q;
        drain_next = drain_kill;
        if (!stall_2a && (drain_kill != '0)) begin
            drain_next = drain_kill - DRAIN_ONE;
        end
    end

    // Next-state and fetch_hold decode. HALTED is entered on the edge where
    // the last in-flight instruction leaves, so HALTING lasts exactly the
    // number of unstalled drain cycles.
    always_comb begin
        state_d     = state_q;
        drain_d     = drain_q;
        step_flag_d = step_flag_q;
        step_done_d = 1'b0;
        fetch_hold  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                fetch_hold = bkpt_match;
                if (halt_req || bkpt_match) begin
                    state_d = ST_HALTING;
                    drain_d = DRAIN_LOAD;
                end
            end
            ST_HALTING: begin
                fetch_hold = 1'b1;
                if (drain_next == '0) begin
                    state_d     = ST_HALTED;
                    drain_d     = '0;
                    step_done_d = step_flag_q;
                    step_flag_d = 1'b0;
                end else begin
                    drain_d = drain_next;
                end
            end
            ST_HALTED: begin
                fetch_hold = 1'b1;
                if (run_req) begin
                    state_d = ST_RUN;
                end else if (step_req) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (!stall_2a) begin
                    state_d     = ST_HALTING;
                    drain_d     = DRAIN_LOAD;
                    step_flag_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State register; reset wins over every request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RESET_HALTED ? ST_HALTED : ST_RUN;
            drain_q      <= '0;
            step_flag_q  <= 1'b0;
            step_done_q  <= 1'b0;
            run_cycles_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            step_flag_q <= step_flag_d;
            step_done_q <= step_done_d;
            if (state_q == ST_RUN) begin
                run_cycles_q <= run_cycles_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_ctl.sv
// ---------------------------------------------------------------------------
// tb_cpu_run_ctl
// Self-checking bench for cpu_run_ctl (DRAIN_CYCLES=4, RESET_HALTED=0).
// Breakpoint scenarios are included when CPU_RUN_CTL_BKPT_EN is defined.
// ---------------------------------------------------------------------------
module tb_cpu_run_ctl;

    localparam int DRAIN = 4;

    typedef struct packed {
        logic        rst;
        logic        halt;
        logic        run;
        logic        step;
        logic        stall;
        logic        kill;
        logic [31:0] pc;
        logic        bv;
        logic [31:0] ba;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic [1:0]  e_state;
        logic        e_fh;
        logic        e_halted;
        logic        e_done;
        logic [31:0] e_runs;
    } vec_t;

    logic        clk = 1'b0;
    stim_t       cur;
    logic        fetch_hold;
    logic        halted;
    logic [1:0]  state;
    logic        step_done;
    logic        bkpt_hit;
    logic [31:0] run_cycles;

    int checks = 0;
    int errors = 0;

    // Reference model: mode follows the port encoding of 'state'
    int          m_mode;
    int          m_left;
    bit          m_stepping;
    bit          m_done;
    bit          m_hit;
    bit          m_arm;
    bit          m_valid = 1'b0;
    int unsigned m_runs;

    always #5 clk = ~clk;

    cpu_run_ctl #(
        .DRAIN_CYCLES (DRAIN),
        .RESET_HALTED (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (cur.rst),
        .halt_req   (cur.halt),
        .run_req    (cur.run),
        .step_req   (cur.step),
        .stall_2a   (cur.stall),
        .kill_4a    (cur.kill),
        .pc_1a      (cur.pc),
        .bkpt_valid (cur.bv),
        .bkpt_addr  (cur.ba),
        .fetch_hold (fetch_hold),
        .halted     (halted),
        .state      (state),
        .step_done  (step_done),
        .bkpt_hit   (bkpt_hit),
        .run_cycles (run_cycles)
    );

    function automatic stim_t idleStim();
        stim_t s;
        s      = '0;
        s.ba   = 32'h0000_0040;
        return s;
    endfunction

    function automatic vec_t row(bit h, bit r, bit st, bit sl, bit k,
                                 logic [1:0] es, bit efh, bit eh, bit ed,
                                 int unsigned eruns);
        vec_t v;
        v.s        = idleStim();
        v.s.halt   = h;
        v.s.run    = r;
        v.s.step   = st;
        v.s.stall  = sl;
        v.s.kill   = k;
        v.e_state  = es;
        v.e_fh     = efh;
        v.e_halted = eh;
        v.e_done   = ed;
        v.e_runs   = eruns;
        return v;
    endfunction

    function automatic bit modelFire();
`ifdef CPU_RUN_CTL_BKPT_EN
        return (m_mode == 0) && m_arm && cur.bv && (cur.pc == cur.ba);
`else
        return 1'b0;
`endif
    endfunction

    task automatic cmp(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Advance the model across the coming clock edge using the current inputs
    task automatic modelStep();
        bit fire;
        bit leaving;
        int old;
        if (cur.rst) begin
            m_mode     = 0;
            m_left     = 0;
            m_stepping = 0;
            m_done     = 0;
            m_hit      = 0;
            m_arm      = 1;
            m_runs     = 0;
            m_valid    = 1;
            return;
        end
        fire    = modelFire();
        old     = m_mode;
        leaving = 0;
        m_done  = 0;
        if (old == 0) m_runs++;
        case (old)
            0: if (cur.halt || fire) begin
                m_mode = 1;
                m_left = DRAIN;
                if (fire) m_hit = 1;
            end
            1: begin
                if (cur.kill && m_left > 1) m_left = 1;
                if (!cur.stall && m_left > 0) m_left--;
                if (m_left == 0) begin
                    m_mode     = 2;
                    m_done     = m_stepping;
                    m_stepping = 0;
                end
            end
            2: begin
                if (cur.run) begin
                    m_mode  = 0;
                    leaving = 1;
                end else if (cur.step) begin
                    m_mode  = 3;
                    leaving = 1;
                end
            end
            default: if (!cur.stall) begin
                m_mode     = 1;
                m_left     = DRAIN;
                m_stepping = 1;
            end
        endcase
        if (leaving) begin
            m_hit = 0;
            m_arm = 0;
        end else if (!cur.stall && (old == 0 || old == 3)) begin
            m_arm = 1;
        end
    endtask

    task automatic checkOutput();
        if (!m_valid) return;
        cmp("state", 32'(state), 32'(m_mode));
        cmp("fetch_hold", 32'(fetch_hold), 32'(m_mode == 1 || m_mode == 2 || modelFire()));
        cmp("halted", 32'(halted), 32'(m_mode == 2));
        cmp("step_done", 32'(step_done), 32'(m_done));
        cmp("bkpt_hit", 32'(bkpt_hit), 32'(m_hit));
        cmp("run_cycles", run_cycles, m_runs);
    endtask

    // Drive one cycle of inputs, check outputs mid-cycle, advance the model
    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        cur = s;
        #1;
        checkOutput();
        modelStep();
    endtask

    task automatic doReset();
        stim_t s;
        s     = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
    endtask

    task automatic waitHalted(input string name, input int budget, output int took);
        took = 0;
        for (int c = 1; c <= budget; c++) begin
            applyStimulus(idleStim());
            if (halted === 1'b1) begin
                took = c;
                break;
            end
        end
        if (took == 0) cmp({name, "_timeout"}, 32'(halted), 32'd1);
    endtask

    vec_t tbl [17];

    initial begin
        stim_t s;
        int    first;
        int    pulses;
        int    took;

        cur = idleStim();

        tbl[0]  = row(0,0,0,0,0, 2'd0, 0,0,0, 0);
        tbl[1]  = row(0,0,0,0,0, 2'd0, 0,0,0, 1);
        tbl[2]  = row(1,0,0,0,0, 2'd0, 0,0,0, 2);
        tbl[3]  = row(0,0,0,0,0, 2'd1, 1,0,0, 3);
        tbl[4]  = row(0,0,0,1,0, 2'd1, 1,0,0, 3);
        tbl[5]  = row(0,0,0,0,0, 2'd1, 1,0,0, 3);
        tbl[6]  = row(0,1,0,0,0, 2'd1, 1,0,0, 3);
        tbl[7]  = row(0,0,0,0,0, 2'd1, 1,0,0, 3);
        tbl[8]  = row(0,0,0,0,0, 2'd2, 1,1,0, 3);
        tbl[9]  = row(0,0,1,1,0, 2'd2, 1,1,0, 3);
        tbl[10] = row(0,0,0,1,0, 2'd3, 0,0,0, 3);
        tbl[11] = row(0,0,0,0,0, 2'd3, 0,0,0, 3);
        tbl[12] = row(0,0,0,0,1, 2'd1, 1,0,0, 3);
        tbl[13] = row(0,0,0,0,0, 2'd2, 1,1,1, 3);
        tbl[14] = row(0,1,1,0,0, 2'd2, 1,1,0, 3);
        tbl[15] = row(0,0,0,0,0, 2'd0, 0,0,0, 3);
        tbl[16] = row(0,0,0,0,0, 2'd0, 0,0,0, 4);

        $display("[TB] table vectors");
        doReset();
        for (int i = 0; i < 17; i++) begin
            applyStimulus(tbl[i].s);
            cmp($sformatf("tbl%0d_state", i), 32'(state), 32'(tbl[i].e_state));
            cmp($sformatf("tbl%0d_fh", i), 32'(fetch_hold), 32'(tbl[i].e_fh));
            cmp($sformatf("tbl%0d_halted", i), 32'(halted), 32'(tbl[i].e_halted));
            cmp($sformatf("tbl%0d_done", i), 32'(step_done), 32'(tbl[i].e_done));
            cmp($sformatf("tbl%0d_runs", i), run_cycles, tbl[i].e_runs);
        end

        $display("[TB] halt at cycle 10");
        doReset();
        for (int c = 1; c <= 9; c++) applyStimulus(idleStim());
        s = idleStim();
        s.halt = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        cmp("halt_fh_c11", 32'(fetch_hold), 32'd1);
        first = 0;
        for (int c = 12; c <= 40; c++) begin
            applyStimulus(idleStim());
            if (halted === 1'b1) begin
                first = c;
                break;
            end
        end
        cmp("halt_cycle", 32'(first), 32'd15);
        cmp("halt_run_cycles", run_cycles, 32'd10);

        $display("[TB] halt with 3 stall cycles");
        doReset();
        for (int c = 1; c <= 9; c++) applyStimulus(idleStim());
        s = idleStim();
        s.halt = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        first = 0;
        for (int c = 12; c <= 40; c++) begin
            s = idleStim();
            s.stall = (c >= 12 && c <= 14);
            applyStimulus(s);
            if (halted === 1'b1) begin
                first = c;
                break;
            end
        end
        cmp("stall_halt_cycle", 32'(first), 32'd18);

        $display("[TB] kill in first draining cycle");
        doReset();
        s = idleStim();
        s.halt = 1'b1;
        applyStimulus(s);
        s = idleStim();
        s.kill = 1'b1;
        applyStimulus(s);
        cmp("kill_state_halting", 32'(state), 32'd1);
        applyStimulus(idleStim());
        cmp("kill_state_halted", 32'(state), 32'd2);

        $display("[TB] single step");
        s = idleStim();
        s.step = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        cmp("step_state", 32'(state), 32'd3);
        cmp("step_fh", 32'(fetch_hold), 32'd0);
        first  = 0;
        pulses = 0;
        for (int k = 2; k <= 12; k++) begin
            applyStimulus(idleStim());
            if (step_done === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        cmp("step_done_pulses", 32'(pulses), 32'd1);
        cmp("step_done_offset", 32'(first), 32'd6);
        s = idleStim();
        s.run  = 1'b1;
        s.step = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        cmp("run_wins_state", 32'(state), 32'd0);

        $display("[TB] reset mid step drain");
        doReset();
        s = idleStim();
        s.halt = 1'b1;
        applyStimulus(s);
        waitHalted("rst_step_halt", 20, took);
        s = idleStim();
        s.step = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        applyStimulus(idleStim());
        s = idleStim();
        s.rst = 1'b1;
        applyStimulus(s);
        applyStimulus(idleStim());
        cmp("rst_step_state", 32'(state), 32'd0);
        cmp("rst_step_runs", run_cycles, 32'd0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(idleStim());
            if (step_done === 1'b1) pulses++;
        end
        cmp("rst_step_no_done", 32'(pulses), 32'd0);

`ifdef CPU_RUN_CTL_BKPT_EN
        $display("[TB] breakpoint");
        doReset();
        s = idleStim();
        s.bv = 1'b1;
        s.pc = 32'h38;
        applyStimulus(s);
        s.pc = 32'h3C;
        applyStimulus(s);
        s.pc = 32'h40;
        applyStimulus(s);
        cmp("bkpt_fh_same_cycle", 32'(fetch_hold), 32'd1);
        first = 0;
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(s);
            if (halted === 1'b1) begin
                first = c;
                break;
            end
        end
        cmp("bkpt_halted", 32'(halted), 32'd1);
        cmp("bkpt_hit_set", 32'(bkpt_hit), 32'd1);
        s.run = 1'b1;
        applyStimulus(s);
        s.run = 1'b0;
        applyStimulus(s);
        cmp("bkpt_resume_state", 32'(state), 32'd0);
        cmp("bkpt_resume_fh", 32'(fetch_hold), 32'd0);
        s.pc = 32'h44;
        applyStimulus(s);
        cmp("bkpt_no_retrigger", 32'(state), 32'd0);
        cmp("bkpt_hit_cleared", 32'(bkpt_hit), 32'd0);
`endif

        $display("[TB] random stimulus");
        doReset();
        for (int n = 0; n < 3000; n++) begin
            s       = idleStim();
            s.rst   = ($urandom_range(99) < 2);
            s.halt  = ($urandom_range(99) < 12);
            s.run   = ($urandom_range(99) < 15);
            s.step  = ($urandom_range(99) < 15);
            s.stall = ($urandom_range(99) < 30);
            s.kill  = ($urandom_range(99) < 10);
            s.bv    = ($urandom_range(1) == 1);
            s.pc    = ($urandom_range(3) == 0) ? 32'h40 : (32'($urandom_range(31)) << 2);
            applyStimulus(s);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
